// File: rtl/wb_stage_cp0_pkg.sv
// Shared types and constants for the write-back stage and its CP0 block.
package wb_stage_cp0_pkg;

  typedef struct packed {
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] badvaddr;
    logic        bd;
    logic [4:0]  rd;
    logic        eret;
    logic        mtc0;
    logic        mfc0;
    logic [4:0]  rt;
    logic [31:0] rt_data;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV   = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  function automatic logic sets_badvaddr(input logic [4:0] code);
    return code inside {EXC_MOD, EXC_TLBL, EXC_TLBS,
                        EXC_ADEL, EXC_ADES};
  endfunction

endpackage

// File: rtl/cp0_regs.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
module cp0_regs
  import wb_stage_cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_we_i,
  input  logic [4:0]  exc_code_i,
  input  logic        exc_bd_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_badvaddr_i,
  input  logic        eret_we_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_wdata_i,
  input  logic [5:0]  ext_int_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o,
  output logic        int_pending_o
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(COUNT_DIV - 1);

  logic [31:0]      badvaddr_q;
  logic [31:0]      count_q;
  logic [31:0]      count_d;
  logic [31:0]      compare_q;
  logic [31:0]      epc_q;
  logic [7:0]       im_q;
  logic             exl_q;
  logic             ie_q;
  logic             bd_q;
  logic             ti_q;
  logic             ti_d;
  logic [7:0]       ip_q;
  logic [4:0]       exccode_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic wr_count;
  logic wr_compare;
  logic div_wrap;
  logic count_inc;
  logic ti_set;

  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  assign wr_status  = mtc0_we_i & ~exc_we_i
                    & (mtc0_addr_i == CP0_STATUS);
  assign wr_cause   = mtc0_we_i & ~exc_we_i
                    & (mtc0_addr_i == CP0_CAUSE);
  assign wr_epc     = mtc0_we_i & ~exc_we_i
                    & (mtc0_addr_i == CP0_EPC);
  assign wr_count   = mtc0_we_i & ~exc_we_i
                    & (mtc0_addr_i == CP0_COUNT);
  assign wr_compare = mtc0_we_i & ~exc_we_i
                    & (mtc0_addr_i == CP0_COMPARE);

  assign div_wrap  = (div_q == DIV_MAX);
  assign count_inc = div_wrap & ~wr_count;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (wr_count || div_wrap) div_d = '0;
  end

  always_comb begin
    count_d = count_q;
    if (wr_count)       count_d = mtc0_wdata_i;
    else if (count_inc) count_d = count_q + 32'd1;
  end

  // Match only on a Count change, so a stale equality can't re-fire.
  assign ti_set = (count_inc | wr_count)
                & (count_d == compare_q);
  assign ti_d   = ~wr_compare & (ti_q | ti_set);

  assign int_pending_o = ie_q & ~exl_q & |(ip_q & im_q);
  assign epc_o         = epc_q;

  always_comb begin
    status_rd = '0;
    status_rd[ST_BEV] = 1'b1;
    status_rd[ST_IM_LO +: 8] = im_q;
    status_rd[ST_EXL] = exl_q;
    status_rd[ST_IE]  = ie_q;
  end

  always_comb begin
    cause_rd = '0;
    cause_rd[CA_BD] = bd_q;
    cause_rd[CA_TI] = ti_q;
    cause_rd[CA_IP_LO +: 8] = ip_q;
    cause_rd[CA_EXC_LO +: 5] = exccode_q;
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badvaddr_q;
      CP0_COUNT:    rdata_o = count_q;
      CP0_COMPARE:  rdata_o = compare_q;
      CP0_STATUS:   rdata_o = status_rd;
      CP0_CAUSE:    rdata_o = cause_rd;
      CP0_EPC:      rdata_o = epc_q;
      default:      rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_q       <= '0;
      exccode_q  <= '0;
      div_q      <= '0;
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
      ti_q    <= ti_d;
      ip_q[7:2] <= {ext_int_i[5] | ti_d, ext_int_i[4:0]};
      if (wr_cause)   ip_q[1:0] <= mtc0_wdata_i[9:8];
      if (wr_compare) compare_q <= mtc0_wdata_i;

      if (exc_we_i) begin
        exl_q     <= 1'b1;
        exccode_q <= exc_code_i;
        if (!exl_q) bd_q <= exc_bd_i;
        if (sets_badvaddr(exc_code_i))
          badvaddr_q <= exc_badvaddr_i;
      end else if (eret_we_i) begin
        exl_q <= 1'b0;
      end else if (wr_status) begin
        im_q  <= mtc0_wdata_i[ST_IM_LO +: 8];
        exl_q <= mtc0_wdata_i[ST_EXL];
        ie_q  <= mtc0_wdata_i[ST_IE];
      end

      if (exc_we_i && !exl_q)
        epc_q <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
      else if (wr_epc)
        epc_q <= mtc0_wdata_i;
    end
  end

endmodule

// File: rtl/wb_stage_cp0.sv
// Write-back stage: commits rf writes, exceptions, eret and interrupts.
module wb_stage_cp0
  import wb_stage_cp0_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = 32'hbfc00380,
  parameter int          COUNT_DIV = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  output logic                       ws_valid,
  output logic [4:0]                 ws_dest,
  output logic [4:0]                 ws_rt,
  output logic [31:0]                ws_rt_value,
  output logic                       ws_reflush,
  output logic [31:0]                ws_flush_pc,
  input  logic [5:0]                 ext_int,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata
);

  logic      valid_q;
  ms_to_ws_t bus_q;

  logic        int_pending;
  logic        take_exc;
  logic        take_eret;
  logic [4:0]  exc_code;
  logic        mtc0_we;
  logic [31:0] cp0_rdata;
  logic [31:0] epc;
  logic        unused_rt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
    end else begin
      valid_q <= ms_to_ws_valid;
      if (ms_to_ws_valid) bus_q <= ms_to_ws_bus;
    end
  end

  assign take_exc  = valid_q & (bus_q.exc_valid | int_pending);
  assign take_eret = valid_q & bus_q.eret & ~take_exc;
  assign exc_code  = bus_q.exc_valid ? bus_q.exc_code : EXC_INT;
  assign mtc0_we   = valid_q & bus_q.mtc0 & ~take_exc;

  cp0_regs #(
    .COUNT_DIV (COUNT_DIV)
  ) u_cp0 (
    .clk            (clk),
    .resetn         (resetn),
    .exc_we_i       (take_exc),
    .exc_code_i     (exc_code),
    .exc_bd_i       (bus_q.bd),
    .exc_pc_i       (bus_q.pc),
    .exc_badvaddr_i (bus_q.badvaddr),
    .eret_we_i      (take_eret),
    .mtc0_we_i      (mtc0_we),
    .mtc0_addr_i    (bus_q.rd),
    .mtc0_wdata_i   (bus_q.rt_data),
    .ext_int_i      (ext_int),
    .raddr_i        (bus_q.rd),
    .rdata_o        (cp0_rdata),
    .epc_o          (epc),
    .int_pending_o  (int_pending)
  );

  assign ws_allowin  = 1'b1;
  assign ws_valid    = valid_q;
  assign ws_reflush  = take_exc | take_eret;
  assign ws_flush_pc = take_exc ? EXC_ENTRY : epc;

  assign rf_we    = valid_q & bus_q.gr_we & ~take_exc
                  & (bus_q.dest != 5'd0);
  assign rf_waddr = bus_q.dest;
  assign rf_wdata = bus_q.mfc0 ? cp0_rdata : bus_q.result;

  assign ws_dest = (valid_q & bus_q.gr_we) ? bus_q.dest : 5'd0;
  assign ws_rt       = rf_we ? bus_q.dest : 5'd0;
  assign ws_rt_value = rf_wdata;

  assign unused_rt = ^bus_q.rt;

endmodule

// File: tb/tb_wb_stage_cp0.sv
// Directed testbench for wb_stage_cp0.
module tb_wb_stage_cp0;
  import wb_stage_cp0_pkg::*;

  logic                       clk = 1'b0;
  logic                       resetn = 1'b0;
  logic                       ms_to_ws_valid = 1'b0;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus = '0;
  logic [5:0]                 ext_int = '0;
  logic                       ws_allowin;
  logic                       ws_valid;
  logic [4:0]                 ws_dest;
  logic [4:0]                 ws_rt;
  logic [31:0]                ws_rt_value;
  logic                       ws_reflush;
  logic [31:0]                ws_flush_pc;
  logic                       rf_we;
  logic [4:0]                 rf_waddr;
  logic [31:0]                rf_wdata;

  int tests = 0;
  int fails = 0;

  wb_stage_cp0 dut (
    .clk            (clk),
    .resetn         (resetn),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .ws_allowin     (ws_allowin),
    .ws_valid       (ws_valid),
    .ws_dest        (ws_dest),
    .ws_rt          (ws_rt),
    .ws_rt_value    (ws_rt_value),
    .ws_reflush     (ws_reflush),
    .ws_flush_pc    (ws_flush_pc),
    .ext_int        (ext_int),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input ms_to_ws_t b);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = b;
    @(posedge clk);
    #1;
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic nop(input logic [31:0] pc);
    ms_to_ws_t b;
    b = '0;
    b.pc = pc;
    issue(b);
  endtask

  task automatic wr_cp0(input logic [4:0] rd, input logic [31:0] d);
    ms_to_ws_t b;
    b = '0;
    b.mtc0 = 1'b1;
    b.rd = rd;
    b.rt_data = d;
    b.pc = 32'hbfc0_0100;
    issue(b);
  endtask

  task automatic rd_cp0(input logic [4:0] rd, output logic [31:0] v);
    ms_to_ws_t b;
    b = '0;
    b.mfc0 = 1'b1;
    b.gr_we = 1'b1;
    b.dest = 5'd2;
    b.rd = rd;
    b.pc = 32'hbfc0_0200;
    issue(b);
    v = rf_wdata;
  endtask

  task automatic eret(input logic [31:0] exp_pc);
    ms_to_ws_t b;
    b = '0;
    b.eret = 1'b1;
    b.pc = 32'hbfc0_0300;
    issue(b);
    chk("eret_reflush", 32'(ws_reflush), 32'd1);
    chk("eret_pc", ws_flush_pc, exp_pc);
  endtask

  initial begin
    ms_to_ws_t   b;
    logic [31:0] v;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ws_valid), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_reflush", 32'(ws_reflush), 32'd0);
    chk("rst_flush_pc", ws_flush_pc, 32'd0);
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_wdata", rf_wdata, 32'd0);
    resetn = 1'b1;

    b = '0;
    b.gr_we = 1'b1;
    b.dest = 5'd8;
    b.result = 32'h1234;
    b.pc = 32'hbfc0_0000;
    issue(b);
    chk("alu_valid", 32'(ws_valid), 32'd1);
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd8);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_reflush", 32'(ws_reflush), 32'd0);
    chk("alu_dest", 32'(ws_dest), 32'd8);
    chk("alu_rt", 32'(ws_rt), 32'd8);
    chk("alu_rt_val", ws_rt_value, 32'h1234);

    b.dest = 5'd0;
    issue(b);
    chk("r0_we", 32'(rf_we), 32'd0);
    chk("r0_rt", 32'(ws_rt), 32'd0);

    rd_cp0(CP0_STATUS, v);
    chk("status_rst", v, 32'h0040_0000);
    wr_cp0(CP0_STATUS, 32'h0000_ff01);
    chk("mtc0_we", 32'(rf_we), 32'd0);
    rd_cp0(CP0_STATUS, v);
    chk("status_wr", v, 32'h0040_ff01);

    b = '0;
    b.exc_valid = 1'b1;
    b.exc_code = EXC_ADES;
    b.bd = 1'b1;
    b.pc = 32'hbfc0_1004;
    b.badvaddr = 32'h3;
    b.gr_we = 1'b1;
    b.dest = 5'd9;
    b.result = 32'h55;
    issue(b);
    chk("exc_reflush", 32'(ws_reflush), 32'd1);
    chk("exc_pc", ws_flush_pc, 32'hbfc0_0380);
    chk("exc_we", 32'(rf_we), 32'd0);
    rd_cp0(CP0_EPC, v);
    chk("exc_epc", v, 32'hbfc0_1000);
    rd_cp0(CP0_CAUSE, v);
    chk("exc_cause", v, 32'h8000_0014);
    rd_cp0(CP0_STATUS, v);
    chk("exc_status", v, 32'h0040_ff03);
    rd_cp0(CP0_BADVADDR, v);
    chk("exc_badva", v, 32'h3);

    b = '0;
    b.exc_valid = 1'b1;
    b.exc_code = EXC_ADEL;
    b.pc = 32'hbfc0_5000;
    b.badvaddr = 32'h77;
    issue(b);
    chk("nest_reflush", 32'(ws_reflush), 32'd1);
    rd_cp0(CP0_EPC, v);
    chk("nest_epc", v, 32'hbfc0_1000);
    rd_cp0(CP0_CAUSE, v);
    chk("nest_cause", v, 32'h8000_0010);
    rd_cp0(CP0_BADVADDR, v);
    chk("nest_badva", v, 32'h77);

    wr_cp0(CP0_EPC, 32'hbfc0_2000);
    eret(32'hbfc0_2000);
    rd_cp0(CP0_STATUS, v);
    chk("eret_status", v, 32'h0040_ff01);

    b = '0;
    b.exc_valid = 1'b1;
    b.exc_code = 5'd8;
    b.mtc0 = 1'b1;
    b.rd = CP0_EPC;
    b.rt_data = 32'h1234_5678;
    b.pc = 32'hbfc0_3000;
    issue(b);
    chk("race_reflush", 32'(ws_reflush), 32'd1);
    rd_cp0(CP0_EPC, v);
    chk("race_epc", v, 32'hbfc0_3000);
    rd_cp0(CP0_BADVADDR, v);
    chk("sys_badva", v, 32'h77);
    rd_cp0(CP0_CAUSE, v);
    chk("sys_cause", v, 32'h0000_0020);
    eret(32'hbfc0_3000);

    rd_cp0(5'd15, v);
    chk("unimpl_rd", v, 32'd0);

    wr_cp0(CP0_COMPARE, 32'd10);
    wr_cp0(CP0_COUNT, 32'd0);
    repeat (18) @(posedge clk);
    #1;
    nop(32'hbfc0_4000);
    chk("ti_early1", 32'(ws_reflush), 32'd0);
    nop(32'hbfc0_4004);
    chk("ti_early2", 32'(ws_reflush), 32'd0);
    nop(32'hbfc0_4008);
    chk("ti_int", 32'(ws_reflush), 32'd1);
    chk("ti_int_pc", ws_flush_pc, 32'hbfc0_0380);
    rd_cp0(CP0_CAUSE, v);
    chk("ti_cause", v, 32'h4000_8000);
    rd_cp0(CP0_EPC, v);
    chk("ti_epc", v, 32'hbfc0_4008);
    wr_cp0(CP0_COMPARE, 32'd1000);
    rd_cp0(CP0_CAUSE, v);
    chk("ti_clear", v, 32'h0000_0000);
    eret(32'hbfc0_4008);

    ext_int = 6'b000001;
    @(posedge clk);
    #1;
    nop(32'hbfc0_6000);
    chk("hw_int", 32'(ws_reflush), 32'd1);
    rd_cp0(CP0_CAUSE, v);
    chk("hw_cause", v, 32'h0000_0400);
    ext_int = '0;
    eret(32'hbfc0_6000);

    b = '0;
    b.gr_we = 1'b1;
    b.dest = 5'd5;
    b.result = 32'hdead;
    issue(b);
    chk("pre_rst_we", 32'(rf_we), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ws_valid), 32'd0);
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_dest", 32'(ws_dest), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_we2", 32'(rf_we), 32'd0);
    resetn = 1'b1;
    rd_cp0(CP0_COUNT, v);
    chk("rst_count", v, 32'd0);
    rd_cp0(CP0_STATUS, v);
    chk("rst_status", v, 32'h0040_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
